// File: rtl/tone_phase_gen_pkg.sv
// Shared definitions for the tone phase generator, the host register decoder and
// the wave lookup stage.
//  - Register map addresses for the byte-wide host port.
//  - CTRL register bit positions.
//  - Helper that extracts the wave type field from a CTRL byte.
package tone_phase_gen_pkg;

  // Host register map
  localparam logic [1:0] REG_FREQ_LO = 2'd0;
  localparam logic [1:0] REG_FREQ_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_PRESC   = 2'd3;

  // CTRL register layout
  localparam int unsigned CTRL_KEY_BIT  = 0;
  localparam int unsigned CTRL_WAVE_LSB = 1;
  localparam int unsigned CTRL_WAVE_MSB = 3;

  function automatic logic [2:0] ctrl_wave_type(input logic [7:0] ctrl);
    return ctrl[CTRL_WAVE_MSB:CTRL_WAVE_LSB];
  endfunction

endpackage

// File: rtl/tone_phase_gen_prescaler.sv
// Reload counter that divides the system clock into phase accumulator ticks.
//  i_clk    : system clock, rising edge
//  i_rst    : asynchronous reset, active-high
//  i_reload : terminal count; o_tick fires when the counter equals it (0 = every cycle)
//  i_clear  : synchronous clear, restarts the count from 0
//  o_tick   : combinational tick, high in the cycle the count equals i_reload
module tone_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_reload,
  input  logic             i_clear,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == i_reload);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tone_phase_gen.sv
// Per-channel phase generator feeding the wave lookup stage.
//  clk_in            : system clock, rising edge
//  rst_in            : asynchronous reset, active-high
//  reg_write_en_in   : host register write strobe (one cycle per write)
//  reg_addr_in       : 0=FREQ_LO 1=FREQ_HI 2=CTRL 3=PRESC
//  reg_data_in       : host write data
//  lut_addr_out      : top ADDR_WIDTH bits of the phase accumulator
//  wave_type_out     : CTRL[3:1]
//  active_out        : channel keyed on
//  sample_strobe_out : one-cycle pulse when lut_addr_out changes on an accumulate
//  period_strobe_out : one-cycle pulse when the accumulator wraps
module tone_phase_gen #(
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  reg_write_en_in,
  input  logic [1:0]            reg_addr_in,
  input  logic [7:0]            reg_data_in,
  output logic [ADDR_WIDTH-1:0] lut_addr_out,
  output logic [2:0]            wave_type_out,
  output logic                  active_out,
  output logic                  sample_strobe_out,
  output logic                  period_strobe_out
);

  import tone_phase_gen_pkg::*;

  // Frequency is written as two bytes, so the shadow is always 16 bits wide and
  // resized onto the accumulator width when committed.
  logic [15:0]            r_freq_shadow;
  logic [15:0]            w_freq_shadow_nxt;
  logic [ACC_WIDTH-1:0]   r_freq_active;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_carry;
  logic [PRESC_WIDTH-1:0] r_presc_reload;
  logic [2:0]             r_wave_type;
  logic                   r_active;
  logic                   r_sample;
  logic                   r_period;

  logic w_wr_lo;
  logic w_wr_hi;
  logic w_wr_ctrl;
  logic w_wr_presc;
  logic w_key_on;
  logic w_key_off;
  logic w_restart;
  logic w_tick;

  assign w_wr_lo    = reg_write_en_in && (reg_addr_in == REG_FREQ_LO);
  assign w_wr_hi    = reg_write_en_in && (reg_addr_in == REG_FREQ_HI);
  assign w_wr_ctrl  = reg_write_en_in && (reg_addr_in == REG_CTRL);
  assign w_wr_presc = reg_write_en_in && (reg_addr_in == REG_PRESC);
  assign w_key_on   = w_wr_ctrl && reg_data_in[CTRL_KEY_BIT];
  assign w_key_off  = w_wr_ctrl && !reg_data_in[CTRL_KEY_BIT];
  // Key-on only restarts a silent channel; a repeat key-on just updates wave type.
  assign w_restart  = w_key_on && !r_active;

  // Shadow value including this cycle's write, so a FREQ write on a carrying tick
  // is the value that gets committed.
  always_comb begin
    w_freq_shadow_nxt = r_freq_shadow;
    if (w_wr_lo) w_freq_shadow_nxt[7:0]  = reg_data_in;
    if (w_wr_hi) w_freq_shadow_nxt[15:8] = reg_data_in;
  end

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_freq_active};

  tone_prescaler #(
    .WIDTH (PRESC_WIDTH)
  ) u_prescaler (
    .i_clk    (clk_in),
    .i_rst    (rst_in),
    .i_reload (r_presc_reload),
    .i_clear  (w_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_freq_shadow  <= '0;
      r_freq_active  <= '0;
      r_acc          <= '0;
      r_presc_reload <= '0;
      r_wave_type    <= '0;
      r_active       <= 1'b0;
      r_sample       <= 1'b0;
      r_period       <= 1'b0;
    end else begin
      r_freq_shadow <= w_freq_shadow_nxt;
      r_sample      <= 1'b0;
      r_period      <= 1'b0;
      if (w_wr_presc) r_presc_reload <= PRESC_WIDTH'(reg_data_in);
      if (w_wr_ctrl)  r_wave_type    <= ctrl_wave_type(reg_data_in);

      if (w_restart) begin
        r_acc         <= '0;
        r_freq_active <= ACC_WIDTH'(r_freq_shadow);
        r_active      <= 1'b1;
      end else if (!r_active) begin
        r_freq_active <= ACC_WIDTH'(r_freq_shadow);
      end else if (w_key_off) begin
        // Key-off wins over a same-cycle tick; phase is frozen where it stands.
        r_active <= 1'b0;
      end else if (w_tick) begin
        r_acc    <= w_sum;
        r_period <= w_carry;
        r_sample <= (w_sum[ACC_WIDTH-1 -: ADDR_WIDTH] != r_acc[ACC_WIDTH-1 -: ADDR_WIDTH]);
        // Retune only at a period boundary so the waveform never glitches mid-cycle.
        if (w_carry) r_freq_active <= ACC_WIDTH'(w_freq_shadow_nxt);
      end
    end
  end

  assign lut_addr_out      = r_acc[ACC_WIDTH-1 -: ADDR_WIDTH];
  assign wave_type_out     = r_wave_type;
  assign active_out        = r_active;
  assign sample_strobe_out = r_sample;
  assign period_strobe_out = r_period;

endmodule
